ram8_sweep: RTL and testbench

Eight-word register bank with a valid/ready write port, a combinational read port and a self-timed clear sequencer. It sits directly downstream of the 8-way load demultiplexer. The block drives the demux `in`/`sel` pair as `load_en`/`load_sel`, and each of the eight one-hot load strobes enables exactly one storage word. It is the write-side building block for RAM64 and larger memories.

---
 rtl/ram8_sweep.sv | 119 +++++++++++
 tb/tb_ram8_sweep.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ram8_sweep.sv
// ram8_sweep: eight-word register bank with a valid/ready write port,
// combinational read port and a self-timed clear sequencer that zeroes
// every word in eight consecutive cycles.

// One storage word; captures d on a one-hot load strobe.
module ram8_sweep_word #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;

  // Hold unless this word's load strobe is high.
  always_comb q_d = ld ? d : q_q;

  // Word register, zero on reset.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) q_q <= '0;
    else          q_q <= q_d;

  assign q = q_q;
endmodule

module ram8_sweep #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_addr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear_req,
  input  logic [2:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             load_en,
  output logic [2:0]       load_sel,
  output logic             busy,
  output logic             clear_done
);
  localparam int NUM_WORDS = 8;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                            state_q, state_d;
  logic [2:0]                        ptr_q, ptr_d;
  logic                              clear_done_q, clear_done_d;
  logic [WIDTH-1:0]                  wr_data;
  logic [NUM_WORDS-1:0]              load;
  logic [NUM_WORDS-1:0][WIDTH-1:0]   mem;

  // Next-state and write-port control. A clear request in IDLE drops
  // in_ready for that cycle so a coincident write is held off, not lost.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    clear_done_d = 1'b0;
    in_ready     = 1'b0;
    busy         = 1'b0;
    load_en      = 1'b0;
    load_sel     = in_addr;
    wr_data      = in_data;
    case (state_q)
      IDLE: begin
        in_ready = ~clear_req;
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = 3'd0;
        end else if (in_valid) begin
          load_en = 1'b1;
        end
      end
      CLEAR: begin
        busy     = 1'b1;
        load_en  = 1'b1;
        load_sel = ptr_q;
        wr_data  = '0;
        ptr_d    = ptr_q + 3'd1;
        if (ptr_q == 3'd7) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, sweep pointer and done pulse.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= 3'd0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      clear_done_q <= clear_done_d;
    end

  assign clear_done = clear_done_q;

  // One-hot demux decode feeding one word per strobe.
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    assign load[k] = load_en & (load_sel == 3'(k));
    ram8_sweep_word #(.WIDTH(WIDTH)) u_word (
      .clock   (clock),
      .reset_n (reset_n),
      .ld      (load[k]),
      .d       (wr_data),
      .q       (mem[k])
    );
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: tb/tb_ram8_sweep.sv
// Scoreboard bench for ram8_sweep: stimulus pushes hand-computed expected
// outputs per cycle; a negedge monitor pops and compares.
module tb_ram8_sweep;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, clear_req;
  logic        in_ready, load_en, busy, clear_done;
  logic [2:0]  in_addr, rd_addr, load_sel;
  logic [15:0] in_data, rd_data;

  ram8_sweep #(.WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .clear_req(clear_req),
    .rd_addr(rd_addr), .rd_data(rd_data), .load_en(load_en),
    .load_sel(load_sel), .busy(busy), .clear_done(clear_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [15:0] rd;
    logic        le;
    logic [2:0]  ls;
    logic        bsy;
    logic        rdy;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (rd_data !== e.rd || load_en !== e.le || load_sel !== e.ls ||
          busy !== e.bsy || in_ready !== e.rdy || clear_done !== e.done) begin
        n_fail++;
        $display("FAIL %s: got rd=%h le=%b ls=%0d busy=%b rdy=%b done=%b, want rd=%h le=%b ls=%0d busy=%b rdy=%b done=%b",
                 e.name, rd_data, load_en, load_sel, busy, in_ready, clear_done,
                 e.rd, e.le, e.ls, e.bsy, e.rdy, e.done);
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic expect_c(input string nm, input logic [15:0] rd, input logic le,
                          input logic [2:0] ls, input logic bsy, input logic rdy,
                          input logic done);
    exp_t e;
    e.name = nm; e.rd = rd; e.le = le; e.ls = ls; e.bsy = bsy; e.rdy = rdy; e.done = done;
    q.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; clear_req = 1'b0;
    in_addr = 3'd0; in_data = 16'h0; rd_addr = 3'd0;
    step(); step();
    expect_c("reset_state", 16'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    step();
    reset_n = 1'b1;
    step();

    // Write then read same cycle: no bypass.
    in_valid = 1'b1; in_addr = 3'd5; in_data = 16'hBEEF; rd_addr = 3'd5;
    expect_c("beef_same_cycle", 16'h0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    expect_c("beef_next_cycle", 16'hBEEF, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0);
    step();

    // Fill on consecutive cycles.
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_addr = 3'(k); in_data = 16'(16'h1111 * (k + 1)); rd_addr = 3'(k);
      expect_c($sformatf("fill_%0d", k), (k == 5) ? 16'hBEEF : 16'h0, 1'b1, 3'(k), 1'b0, 1'b1, 1'b0);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k); in_addr = 3'(k);
      expect_c($sformatf("read_%0d", k), 16'(16'h1111 * (k + 1)), 1'b0, 3'(k), 1'b0, 1'b1, 1'b0);
      step();
    end

    // Clear sweep with in_valid held high throughout.
    clear_req = 1'b1; in_addr = 3'd3; rd_addr = 3'd0;
    expect_c("clear_accept", 16'h1111, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    step();
    clear_req = 1'b0;
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1; in_data = 16'hDEAD; rd_addr = 3'(j);
      expect_c($sformatf("clear_cyc_%0d", j), 16'(16'h1111 * (j + 1)), 1'b1, 3'(j), 1'b1, 1'b0, 1'b0);
      step();
    end
    in_valid = 1'b0; rd_addr = 3'd3;
    expect_c("clear_done_pulse", 16'h0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b1);
    step();
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      expect_c($sformatf("cleared_%0d", k), 16'h0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
      step();
    end

    // Clear and write in the same IDLE cycle: clear first, write held.
    clear_req = 1'b1; in_valid = 1'b1; in_addr = 3'd2; in_data = 16'h00AA; rd_addr = 3'd2;
    expect_c("clr_wr_collide", 16'h0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    step();
    clear_req = 1'b0;
    for (int j = 0; j < 8; j++) begin
      expect_c($sformatf("held_clear_%0d", j), 16'h0, 1'b1, 3'(j), 1'b1, 1'b0, 1'b0);
      step();
    end
    expect_c("held_write_lands", 16'h0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    expect_c("held_write_read", 16'h00AA, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
    step();

    // Reset in the middle of a clear.
    for (int k = 4; k < 8; k++) begin
      in_valid = 1'b1; in_addr = 3'(k); in_data = 16'(16'h0A00 + k); rd_addr = 3'(k);
      expect_c($sformatf("prefill_%0d", k), 16'h0, 1'b1, 3'(k), 1'b0, 1'b1, 1'b0);
      step();
    end
    in_valid = 1'b0; clear_req = 1'b1; in_addr = 3'd1; rd_addr = 3'd6;
    expect_c("mid_clear_accept", 16'h0A06, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    step();
    clear_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      rd_addr = 3'(4 + j);
      expect_c($sformatf("mid_clear_%0d", j), 16'(16'h0A04 + j), 1'b1, 3'(j), 1'b1, 1'b0, 1'b0);
      step();
    end
    reset_n = 1'b0; rd_addr = 3'd5;
    expect_c("mid_reset_now", 16'h0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    step();
    for (int k = 4; k < 8; k++) begin
      rd_addr = 3'(k);
      expect_c($sformatf("reset_word_%0d", k), 16'h0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
      step();
    end
    reset_n = 1'b1;
    step();
    rd_addr = 3'd7;
    expect_c("post_reset_no_done", 16'h0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    step();

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clock);
    if (q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
